// File: rtl/bit_reverse_collect_pkg.sv
// Shared definitions for the bit source / bit collector pair:
// FSM encoding, ASCII bit characters and default frame geometry.
package bit_reverse_collect_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } collect_state_t;

    localparam logic [7:0]  ASCII_ZERO        = 8'h30;
    localparam logic [7:0]  ASCII_ONE         = 8'h31;
    localparam int unsigned DEFAULT_FRAME_LEN = 8;
    localparam int unsigned DEFAULT_ADDR_W    = 4;

endpackage

// File: rtl/bit_reverse_collect_bit_char_decode.sv
// Combinational ASCII bit-character decoder: char -> {legal, bit}.
module bit_char_decode
    import bit_reverse_collect_pkg::*;
#(
    parameter logic [7:0] CHAR_ZERO = ASCII_ZERO,
    parameter logic [7:0] CHAR_ONE  = ASCII_ONE
) (
    input  logic [7:0] char_in,
    output logic       legal,
    output logic       bit_val
);

    assign legal   = (char_in == CHAR_ZERO) || (char_in == CHAR_ONE);
    assign bit_val = (char_in == CHAR_ONE);

endmodule

// File: rtl/bit_reverse_collect.sv
// Collects position-tagged ASCII bit characters into a frame and emits the
// bit-reversed word through a one-deep valid/ready output buffer.
module bit_reverse_collect
    import bit_reverse_collect_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned ADDR_LAG  = 1,
    parameter logic [7:0]  CHAR_ZERO = ASCII_ZERO,
    parameter logic [7:0]  CHAR_ONE  = ASCII_ONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           bit_in,
    input  logic [ADDR_W-1:0]    addr_in,
    output logic [FRAME_LEN-1:0] rev_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 char_err,
    output logic                 seq_err,
    output logic                 ovf
);

    collect_state_t        state;
    logic [ADDR_W-1:0]     addr_q1;
    logic [ADDR_W-1:0]     pos;
    logic [ADDR_W-1:0]     expect_pos;
    logic [FRAME_LEN-1:0]  asm_q;
    logic [FRAME_LEN-1:0]  w_next;
    logic [FRAME_LEN-1:0]  rev_word;
    logic                  legal;
    logic                  dec_bit;
    logic                  sample_valid;
    logic                  pos_is_first;
    logic                  pos_is_last;
    logic                  word_done;

    bit_char_decode #(
        .CHAR_ZERO (CHAR_ZERO),
        .CHAR_ONE  (CHAR_ONE)
    ) u_decode (
        .char_in (bit_in),
        .legal   (legal),
        .bit_val (dec_bit)
    );

    // The source drives a character one cycle after its address when lagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q1 <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            addr_q1 <= addr_in;
        end
    end

    assign pos          = (ADDR_LAG != 0) ? addr_q1 : addr_in;
    assign sample_valid = (pos != '0);
    assign pos_is_first = (pos == ADDR_W'(1));
    assign pos_is_last  = (pos == ADDR_W'(FRAME_LEN));

    // A first-position store starts from a clean word so nothing leaks across frames.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        w_next = pos_is_first ? '0 : asm_q;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (pos == ADDR_W'(k + 1)) begin
                w_next[k] = dec_bit;
            end
        end
    end

    for (genvar i = 0; i < FRAME_LEN; i++) begin : g_rev
        assign rev_word[i] = w_next[FRAME_LEN-1-i];
    end

    assign word_done = sample_valid && (state == COLLECT) && (pos == expect_pos)
                       && legal && pos_is_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            expect_pos <= '0;
            asm_q      <= '0;
            char_err   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            char_err <= 1'b0;
            seq_err  <= 1'b0;
            if (sample_valid) begin
                case (state)
                    HUNT: begin
                        if (pos_is_first) begin
                            if (legal) begin
                                asm_q      <= w_next;
                                expect_pos <= ADDR_W'(2);
                                state      <= COLLECT;
                            end else begin
                                char_err <= 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        // Sequence errors outrank character errors in the same sample.
                        if (pos != expect_pos) begin
                            seq_err <= 1'b1;
                            if (pos_is_first && legal) begin
                                asm_q      <= w_next;
                                expect_pos <= ADDR_W'(2);
                            end else begin
                                state <= HUNT;
                            end
                        end else if (!legal) begin
                            char_err <= 1'b1;
                            state    <= HUNT;
                        end else begin
                            asm_q      <= w_next;
                            expect_pos <= expect_pos + ADDR_W'(1);
                            if (pos_is_last) begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // One-deep output buffer: a completed word is dropped if the slot stays occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rev_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (word_done) begin
            if (!out_valid || out_ready) begin
                rev_out   <= rev_word;
                out_valid <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
